// File: rtl/pc_redirect_unit.sv
// Owns the architectural fetch PC: steps sequentially, applies EXE control transfers,
// and traps misaligned redirect targets through a handshaked exception.
module pc_redirect_unit #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    C_EXT        = 0,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  exe_valid_i,
    output logic                  exe_ready_o,
    input  logic [ADDR_WIDTH-1:0] exe_pc_i,
    input  logic [DATA_WIDTH-1:0] exe_out_i,
    input  logic [DATA_WIDTH-1:0] exe_op3_i,
    input  logic [1:0]            exe_pc_ctrl_i,
    input  logic                  exe_ilen_i,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic                  if_valid_o,
    input  logic                  if_ready_i,
    output logic                  flush_o,
    output logic                  exc_valid_o,
    input  logic                  exc_ready_i,
    output logic [ADDR_WIDTH-1:0] exc_tval_o,
    input  logic [ADDR_WIDTH-1:0] trap_vec_i,
    output logic [CNT_WIDTH-1:0]  redir_cnt_o
);

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_SET = 2'd1;
    localparam logic [1:0] PC_ADD = 2'd2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tval_q, tval_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] out_addr;
    logic [ADDR_WIDTH-1:0] op3_addr;
    logic [ADDR_WIDTH-1:0] ilen;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] target;
    logic                  transfer;
    logic                  redirect;
    logic                  misaligned;

    // EXE operands become addresses modulo 2^ADDR_WIDTH
    generate
        if (DATA_WIDTH >= ADDR_WIDTH) begin : g_trunc
            assign out_addr = exe_out_i[ADDR_WIDTH-1:0];
            assign op3_addr = exe_op3_i[ADDR_WIDTH-1:0];
        end else begin : g_ext
            assign out_addr = ADDR_WIDTH'(exe_out_i);
            assign op3_addr = ADDR_WIDTH'(exe_op3_i);
        end
    endgenerate

    assign ilen   = ((C_EXT != 0) && exe_ilen_i) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);
    assign seq_pc = exe_pc_i + ilen;

    always_comb begin
        target = seq_pc;
        case (exe_pc_ctrl_i)
            PC_INC:  target = seq_pc;
            PC_SET:  target = {out_addr[ADDR_WIDTH-1:1], 1'b0};
            PC_ADD:  target = exe_pc_i + out_addr;
            default: target = exe_out_i[0] ? (exe_pc_i + op3_addr) : seq_pc;
        endcase
    end

    assign misaligned = (C_EXT != 0) ? target[0] : (target[1:0] != 2'b00);
    assign transfer   = exe_valid_i & exe_ready_o;
    assign redirect   = transfer & (target != seq_pc);

    // A redirect takes priority over the sequential fetch step in the same cycle
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect) begin
                    if (misaligned) begin
                        tval_d  = target;
                        state_d = TRAP;
                    end else begin
                        pc_d = target;
                        if (!(&cnt_q)) begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end else if (if_ready_i) begin
                    pc_d = pc_q + ADDR_WIDTH'(4);
                end
            end
            TRAP: begin
                if (exc_ready_i) begin
                    pc_d    = trap_vec_i;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            tval_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            cnt_q   <= cnt_d;
        end
    end

    assign exe_ready_o = (state_q == RUN);
    assign if_valid_o  = (state_q == RUN);
    assign if_pc_o     = pc_q;
    assign flush_o     = redirect;
    assign exc_valid_o = (state_q == TRAP);
    assign exc_tval_o  = tval_q;
    assign redir_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench: two instances share stimulus, one 4-byte-only with a 2-bit counter,
// one with compressed support, so alignment and saturation differ between them.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rstn;
    logic        exe_valid;
    logic [31:0] exe_pc;
    logic [31:0] exe_out;
    logic [31:0] exe_op3;
    logic [1:0]  exe_pc_ctrl;
    logic        exe_ilen;
    logic        if_ready;
    logic        exc_ready;
    logic [31:0] trap_vec;

    logic        a_exe_ready, a_if_valid, a_flush, a_exc_valid;
    logic [31:0] a_if_pc, a_exc_tval;
    logic [1:0]  a_cnt;
    logic        b_exe_ready, b_if_valid, b_flush, b_exc_valid;
    logic [31:0] b_if_pc, b_exc_tval;
    logic [15:0] b_cnt;

    int errors = 0;
    int checks = 0;

    pc_redirect_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h1000), .C_EXT(0), .CNT_WIDTH(2)
    ) dut_a (
        .clk(clk), .rstn(rstn),
        .exe_valid_i(exe_valid), .exe_ready_o(a_exe_ready),
        .exe_pc_i(exe_pc), .exe_out_i(exe_out), .exe_op3_i(exe_op3),
        .exe_pc_ctrl_i(exe_pc_ctrl), .exe_ilen_i(exe_ilen),
        .if_pc_o(a_if_pc), .if_valid_o(a_if_valid), .if_ready_i(if_ready),
        .flush_o(a_flush), .exc_valid_o(a_exc_valid), .exc_ready_i(exc_ready),
        .exc_tval_o(a_exc_tval), .trap_vec_i(trap_vec), .redir_cnt_o(a_cnt)
    );

    pc_redirect_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h1000), .C_EXT(1), .CNT_WIDTH(16)
    ) dut_b (
        .clk(clk), .rstn(rstn),
        .exe_valid_i(exe_valid), .exe_ready_o(b_exe_ready),
        .exe_pc_i(exe_pc), .exe_out_i(exe_out), .exe_op3_i(exe_op3),
        .exe_pc_ctrl_i(exe_pc_ctrl), .exe_ilen_i(exe_ilen),
        .if_pc_o(b_if_pc), .if_valid_o(b_if_valid), .if_ready_i(if_ready),
        .flush_o(b_flush), .exc_valid_o(b_exc_valid), .exc_ready_i(exc_ready),
        .exc_tval_o(b_exc_tval), .trap_vec_i(trap_vec), .redir_cnt_o(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one payload for exactly one cycle; caller checks flush at the following negedge
    task automatic applyStimulus(input logic [1:0] ctrl, input logic [31:0] pc,
                                 input logic [31:0] out, input logic [31:0] op3);
        @(posedge clk); #1;
        exe_valid   = 1'b1;
        exe_pc_ctrl = ctrl;
        exe_pc      = pc;
        exe_out     = out;
        exe_op3     = op3;
        exe_ilen    = 1'b0;
    endtask

    task automatic dropValid();
        @(posedge clk); #1;
        exe_valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; exe_valid = 1'b0; exe_pc = '0; exe_out = '0; exe_op3 = '0;
        exe_pc_ctrl = 2'd0; exe_ilen = 1'b0; if_ready = 1'b1; exc_ready = 1'b0; trap_vec = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_if_valid", {31'b0, a_if_valid}, 32'd0);
        checkOutput("rst_exe_ready", {31'b0, a_exe_ready}, 32'd0);
        checkOutput("rst_flush", {31'b0, a_flush}, 32'd0);
        checkOutput("rst_exc_valid", {31'b0, a_exc_valid}, 32'd0);
        checkOutput("rst_tval", a_exc_tval, 32'd0);
        checkOutput("rst_cnt", {30'b0, a_cnt}, 32'd0);

        @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);
        checkOutput("boot_if_valid", {31'b0, a_if_valid}, 32'd0);
        @(negedge clk);
        checkOutput("run_if_valid", {31'b0, a_if_valid}, 32'd1);
        checkOutput("run_exe_ready", {31'b0, a_exe_ready}, 32'd1);
        checkOutput("fetch_pc0", a_if_pc, 32'h1000);
        @(negedge clk);
        checkOutput("fetch_pc1", a_if_pc, 32'h1004);
        @(negedge clk);
        checkOutput("fetch_pc2", a_if_pc, 32'h1008);

        // Taken conditional branch
        applyStimulus(2'd3, 32'h2000, 32'd1, 32'h40);
        @(negedge clk);
        checkOutput("cond_flush", {31'b0, a_flush}, 32'd1);
        dropValid();
        @(negedge clk);
        checkOutput("cond_pc_a", a_if_pc, 32'h2040);
        checkOutput("cond_pc_b", b_if_pc, 32'h2040);
        checkOutput("cond_cnt", {30'b0, a_cnt}, 32'd1);
        checkOutput("cond_flush_drop", {31'b0, a_flush}, 32'd0);

        // Not-taken conditional branch
        applyStimulus(2'd3, 32'h2000, 32'd0, 32'h40);
        @(negedge clk);
        checkOutput("nt_flush", {31'b0, a_flush}, 32'd0);
        dropValid();
        @(negedge clk);
        checkOutput("nt_cnt", {30'b0, a_cnt}, 32'd1);

        // 0x3003 clears to 0x3002: misaligned for 4-byte, legal with compressed support
        applyStimulus(2'd1, 32'h2800, 32'h3003, 32'h0);
        @(negedge clk);
        checkOutput("mis_flush_a", {31'b0, a_flush}, 32'd1);
        checkOutput("mis_flush_b", {31'b0, b_flush}, 32'd1);
        dropValid();
        @(negedge clk);
        checkOutput("mis_tval", a_exc_tval, 32'h3002);
        checkOutput("mis_cnt_a", {30'b0, a_cnt}, 32'd1);
        checkOutput("cext_pc_b", b_if_pc, 32'h3002);
        checkOutput("cext_exc_b", {31'b0, b_exc_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("trap_exc_valid", {31'b0, a_exc_valid}, 32'd1);
            checkOutput("trap_if_valid", {31'b0, a_if_valid}, 32'd0);
            checkOutput("trap_exe_ready", {31'b0, a_exe_ready}, 32'd0);
            @(negedge clk);
        end
        exc_ready = 1'b1; trap_vec = 32'h100;
        @(posedge clk); #1; exc_ready = 1'b0;
        @(negedge clk);
        checkOutput("trap_exit_exc", {31'b0, a_exc_valid}, 32'd0);
        checkOutput("trap_vec_pc", a_if_pc, 32'h100);
        checkOutput("trap_exit_flush", {31'b0, a_flush}, 32'd0);

        // Address wrap through PC_ADD
        applyStimulus(2'd2, 32'hFFFF_FFF0, 32'h20, 32'h0);
        @(negedge clk);
        checkOutput("wrap_flush", {31'b0, a_flush}, 32'd1);
        dropValid();
        @(negedge clk);
        checkOutput("wrap_pc", a_if_pc, 32'h10);
        checkOutput("wrap_cnt", {30'b0, a_cnt}, 32'd2);

        // Fetch handshake is active every RUN cycle, so the redirect must win over pc+4
        applyStimulus(2'd1, 32'h4000, 32'h500, 32'h0);
        dropValid();
        @(negedge clk);
        checkOutput("redir_wins", a_if_pc, 32'h500);
        checkOutput("cnt_three", {30'b0, a_cnt}, 32'd3);

        applyStimulus(2'd1, 32'h4000, 32'h600, 32'h0);
        applyStimulus(2'd1, 32'h4000, 32'h700, 32'h0);
        dropValid();
        @(negedge clk);
        checkOutput("sat_pc", a_if_pc, 32'h700);
        checkOutput("sat_cnt_a", {30'b0, a_cnt}, 32'd3);
        checkOutput("cnt_b", {16'b0, b_cnt}, 32'd6);

        // Reset while trapped
        applyStimulus(2'd1, 32'h2800, 32'h3003, 32'h0);
        dropValid();
        @(negedge clk);
        checkOutput("trap2_exc", {31'b0, a_exc_valid}, 32'd1);
        @(posedge clk); #1; rstn = 1'b0;
        @(negedge clk);
        checkOutput("trap2_exc", {31'b0, a_exc_valid}, 32'd1);
        @(negedge clk);
        checkOutput("rst_trap_exc", {31'b0, a_exc_valid}, 32'd0);
        checkOutput("rst_trap_flush", {31'b0, a_flush}, 32'd0);
        checkOutput("rst_trap_tval", a_exc_tval, 32'd0);
        checkOutput("rst_trap_cnt", {30'b0, a_cnt}, 32'd0);
        checkOutput("rst_trap_pc", a_if_pc, 32'h1000);
        @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);
        checkOutput("reboot_if_valid", {31'b0, a_if_valid}, 32'd0);
        @(negedge clk);
        checkOutput("rerun_if_valid", {31'b0, a_if_valid}, 32'd1);
        checkOutput("rerun_pc", a_if_pc, 32'h1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised successor to the fixed-width EXE→PC payload: owns the architectural fetch PC.
- Accepts EXE→PC control transfers over a valid/ready handshake and computes the next PC for all four pc_ctrl modes.
- Supports 2- or 4-byte instruction lengths, detects misaligned targets and raises a handshaked exception, and counts redirects.
- Sits between the EXE stage and the IF stage: feeds if_pc_o to fetch, and asserts flush_o to squash wrong-path work.

Parameters:
- ADDR_WIDTH, 32, PC/address width.
- DATA_WIDTH, 32, EXE result/operand width; truncated modulo 2^ADDR_WIDTH when used as an address.
- RESET_VECTOR, 0, PC value after reset; must be aligned.
- C_EXT, 0, 1 = 2-byte alignment and ilen 2 allowed; 0 = 4-byte only.
- CNT_WIDTH, 16, redirect counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- exe_valid_i  in  1  EXE payload valid
- exe_ready_o  out  1  unit can accept payload
- exe_pc_i  in  ADDR_WIDTH  PC of the instruction in EXE
- exe_out_i  in  DATA_WIDTH  EXE result (JALR target, PC offset, or compare flag in bit 0)
- exe_op3_i  in  DATA_WIDTH  branch immediate
- exe_pc_ctrl_i  in  2  PC_INC=0, PC_SET=1, PC_ADD=2, PC_COND=3
- exe_ilen_i  in  1  0 = 4-byte instruction, 1 = 2-byte (ignored, forced to 4, when C_EXT=0)
- if_pc_o  out  ADDR_WIDTH  fetch address
- if_valid_o  out  1  fetch request valid
- if_ready_i  in  1  fetch accepted the request
- flush_o  out  1  squash younger in-flight instructions
- exc_valid_o  out  1  misaligned-target exception pending
- exc_ready_i  in  1  trap logic accepts the exception
- exc_tval_o  out  ADDR_WIDTH  faulting target
- trap_vec_i  in  ADDR_WIDTH  trap handler address
- redir_cnt_o  out  CNT_WIDTH  redirect count, saturating

Behaviour:
- Reset (rstn=0 at posedge):
  - pc_q = RESET_VECTOR, state = BOOT.
  - Outputs: if_valid_o=0, exe_ready_o=0, flush_o=0, exc_valid_o=0, exc_tval_o=0, redir_cnt_o=0.
  - Reset mid-operation aborts any pending exception or redirect with no residual pulse.
- States:
  - BOOT: lasts exactly 1 cycle, then → RUN.
  - RUN: if_valid_o=1, exe_ready_o=1, if_pc_o=pc_q.
  - TRAP: if_valid_o=0, exe_ready_o=0, exc_valid_o=1.
- ilen = 2 when C_EXT=1 and exe_ilen_i=1, else 4.
- Sequential fetch: in RUN with if_valid_o & if_ready_i and no redirect, pc_q ← pc_q + 4 next cycle. Fetch always steps by 4; compressed handling belongs to the aligner.
- Target computation (combinational, all arithmetic modulo 2^ADDR_WIDTH):
  - PC_INC: exe_pc + ilen
  - PC_SET: exe_out with bit 0 cleared
  - PC_ADD: exe_pc + exe_out
  - PC_COND: exe_out[0] ? exe_pc + exe_op3 : exe_pc + ilen
- Transfer = exe_valid_i & exe_ready_o. A transfer is a redirect when target ≠ exe_pc + ilen.
- Misaligned target: target[1:0]≠0 when C_EXT=0, or target[0]≠0 when C_EXT=1.
- Redirect, aligned:
  - flush_o=1 combinationally in the transfer cycle.
  - pc_q ← target.
  - redir_cnt_o increments; it saturates at all-ones.
  - Any fetch handshake in the same cycle is squashed by flush_o and does not advance pc_q (redirect wins).
- Redirect, misaligned:
  - flush_o=1 in the transfer cycle.
  - exc_tval_o ← target; state → TRAP.
  - redir_cnt_o is not incremented.
- Non-redirect transfer: no side effect.
- TRAP: on exc_ready_i, pc_q ← trap_vec_i, exc_valid_o drops next cycle, state → RUN, no flush.
- Latency: redirect target appears on if_pc_o 1 cycle after the transfer.
- Holding rule: exe_* inputs must be held stable while exe_valid_i=1 and exe_ready_o=0.

Test Plan:
- Reset with RESET_VECTOR=0x1000, if_ready_i=1 → BOOT 1 cycle, then if_pc_o = 0x1000, 0x1004, 0x1008 on successive cycles.
- PC_COND, exe_pc=0x2000, exe_out=1, op3=0x40 → flush_o pulse, if_pc_o=0x2040 next cycle, redir_cnt_o=1. Repeat with exe_out=0 → no flush, count unchanged.
- PC_SET, exe_out=0x3003, C_EXT=0 → target 0x3002 misaligned: flush_o, exc_valid_o=1, exc_tval_o=0x3002; hold exc_ready_i=0 for 3 cycles (exc_valid_o stays 1), then 1 with trap_vec_i=0x100 → if_pc_o=0x100. With C_EXT=1 the same payload redirects to 0x3002.
- PC_ADD, exe_pc=0xFFFFFFF0, exe_out=0x20 → wraps to target 0x10.
- Redirect and fetch handshake in the same cycle → pc_q becomes target, not pc+4.
- CNT_WIDTH=2, 5 redirects → redir_cnt_o saturates at 3.
- Reset asserted while in TRAP → exc_valid_o=0 and BOOT next cycle.
